mux_sel_arbiter: RTL and testbench
==================================

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, meaning: the maximum number of accepted beats per grant before rotation; legal range is 1..15.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port req, input, 4 bits: the per-channel request, where bit i means channel i (a/b/c/d) has data.
REQ-005 Port out_ready, input, 1 bit: the downstream consumer accepts the current beat.
REQ-006 Port sel, output, 2 bits: the registered channel select driven to the downstream 4:1 mux (0=a, 1=b, 2=c, 3=d).
REQ-007 Port grant, output, 4 bits: the registered one-hot grant, equal to 1<<sel while out_valid=1, else 0.
REQ-008 Port out_valid, output, 1 bit: the mux output selected by sel is valid this cycle.
REQ-009 Port beat_cnt, output, 4 bits: the number of beats accepted in the current grant.

Function
REQ-010 The block SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-011 In IDLE with req==0, all outputs SHALL hold their IDLE values: out_valid=0, grant=0, beat_cnt=0, and sel unchanged.
REQ-012 In IDLE with req!=0, the block SHALL select, at the next edge, the first set req bit scanning upward from ptr modulo 4, load sel, and enter GRANT.
REQ-013 ptr is a 2-bit priority pointer, internal and registered.
REQ-014 Arbitration latency SHALL be 1 cycle: a req seen at edge k SHALL produce out_valid=1 after edge k+1.
REQ-015 In GRANT, out_valid SHALL be 1; sel and grant SHALL stay stable until release, regardless of req changes.
REQ-016 A beat is accepted in a cycle where out_valid and out_ready are both 1; on acceptance beat_cnt SHALL increment by 1.
REQ-017 Release condition: a beat is accepted AND (beat_cnt+1==MAX_BURST OR req[sel]==0 in that cycle).
REQ-018 On release, at the next edge: the FSM returns to IDLE; ptr<=sel+1 (wrapping 3 to 0); beat_cnt<=0; out_valid<=0.
REQ-019 Exactly one bubble cycle SHALL occur between consecutive grants.
REQ-020 If req[sel] drops without acceptance, the block SHALL keep out_valid=1, i.e. no retraction of a presented beat.
REQ-021 With out_ready=0 indefinitely, GRANT SHALL hold indefinitely, with no timeout.
REQ-022 With MAX_BURST=1, every grant SHALL release after its first accepted beat.
REQ-023 Counter width SHALL be 4 bits, and beat_cnt SHALL never exceed MAX_BURST-1 while out_valid=1.

Reset
REQ-024 Asserting rst SHALL asynchronously force: state=IDLE, sel=0, grant=0, out_valid=0, beat_cnt=0, ptr=0.
REQ-025 Reset asserted mid-GRANT SHALL drop out_valid immediately, without waiting for a clock edge, and discard the in-progress burst.
REQ-026 After deassertion, the first arbitration SHALL start from ptr=0.

Structure
REQ-027 A shared package mux_sel_pkg SHALL hold the state enum (IDLE, GRANT), the channel-count constant NUM_CH=4, and the select width SEL_W=2.
REQ-028 One sub-module, rr_pick, SHALL be purely combinational: inputs req and ptr, outputs a 2-bit index and an any flag.
REQ-029 The FSM, the counters and the output registers SHALL reside in mux_sel_arbiter.

Verification
REQ-030 Reset, then req=4'b0100 with out_ready=1 -> one cycle later sel=2, grant=4'b0100, out_valid=1.
REQ-031 With req=4'b1111 held, out_ready=1 and MAX_BURST=4 -> grant order ch0, ch1, ch2, ch3, ch0, each 4 beats with a one-cycle bubble between grants.
REQ-032 Grant ch1, set out_ready=0 for 10 cycles and drop req[1] -> out_valid stays 1 and sel stays 1 for those cycles; when out_ready=1 for one cycle, release occurs and the next edge shows out_valid=0.
REQ-033 After ch3 releases with req=4'b1001 -> the next grant is ch0, confirming ptr wrap from 3 to 0.
REQ-034 Assert rst mid-burst at beat_cnt=2 -> out_valid=0 and grant=0 in the same cycle without a clock edge; after release, req=4'b1010 grants ch1.
REQ-035 With MAX_BURST=1 and req=4'b0011 -> grants alternate ch0, ch1, each with one beat.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the 4-channel mux select arbiter.
// Holds the FSM state enum, channel count and select width.
package mux_sel_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning
// upward from ptr (mod NUM_CH). Ports: req, ptr -> idx, any.
module rr_pick
  import mux_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  logic [SEL_W-1:0] cand;

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |req;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin burst arbiter driving a downstream 4:1 mux select.
// Ports: clk, rst (async high), req, out_ready -> sel, grant,
// out_valid, beat_cnt. FSM, counters and output regs live here.
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] grant,
  output logic              out_valid,
  output logic [3:0]        beat_cnt
);

  localparam logic [3:0] MB = 4'(MAX_BURST);

  state_t            state, state_n;
  logic [SEL_W-1:0]  ptr, ptr_n;
  logic [SEL_W-1:0]  sel_n;
  logic [NUM_CH-1:0] grant_n;
  logic              valid_n;
  logic [3:0]        cnt_n;

  logic [SEL_W-1:0]  pick;
  logic              any;
  logic              accept;
  logic              last;
  logic              done;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick),
    .any (any)
  );

  assign accept = out_valid & out_ready;
  assign last   = (beat_cnt + 4'd1) == MB;
  // Release on an accepted beat that ends the burst or the
  // channel's request.
  assign done   = accept & (last | ~req[sel]);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    grant_n = grant;
    valid_n = out_valid;
    cnt_n   = beat_cnt;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_n = GRANT;
          sel_n   = pick;
          grant_n = {{(NUM_CH-1){1'b0}}, 1'b1} << pick;
          valid_n = 1'b1;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (done) begin
          state_n = IDLE;
          ptr_n   = sel + SEL_W'(1);
          grant_n = '0;
          valid_n = 1'b0;
          cnt_n   = '0;
        end else if (accept) begin
          cnt_n = beat_cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      sel       <= sel_n;
      grant     <= grant_n;
      out_valid <= valid_n;
      beat_cnt  <= cnt_n;
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter (MAX_BURST 4 and 1).
// Scoreboard of per-cycle expected outputs from a reference model.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       out_ready = 1'b0;

  logic [1:0] sel4, sel1;
  logic [3:0] grant4, grant1;
  logic       valid4, valid1;
  logic [3:0] cnt4, cnt1;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_BURST(4)) u4 (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel4),
    .grant     (grant4),
    .out_valid (valid4),
    .beat_cnt  (cnt4)
  );

  mux_sel_arbiter #(.MAX_BURST(1)) u1 (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel1),
    .grant     (grant1),
    .out_valid (valid1),
    .beat_cnt  (cnt1)
  );

  typedef struct {
    logic       st;
    logic [1:0] ptr;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic [3:0] cnt;
  } model_t;

  typedef struct {
    model_t a;
    model_t b;
  } exp_t;

  model_t m4, m1;
  exp_t   sbq[$];
  int     ord4[$];
  int     ord1[$];
  logic   pv4, pv1;

  function automatic model_t mreset();
    model_t m;
    m.st = 1'b0; m.ptr = '0; m.sel = '0;
    m.grant = '0; m.valid = 1'b0; m.cnt = '0;
    return m;
  endfunction

  function automatic model_t mstep(model_t m, logic [3:0] r,
                                   logic rdy, int mb);
    model_t n = m;
    int     c;
    if (!m.st) begin
      if (r != 4'd0) begin
        for (int k = 0; k < 4; k++) begin
          c = (int'(m.ptr) + k) % 4;
          if (r[c]) begin
            n.sel = 2'(c);
            break;
          end
        end
        n.st = 1'b1;
        n.grant = 4'd1 << n.sel;
        n.valid = 1'b1;
        n.cnt = '0;
      end
    end else if (rdy) begin
      if (int'(m.cnt) + 1 == mb || !r[m.sel]) begin
        n.st = 1'b0;
        n.ptr = m.sel + 2'd1;
        n.cnt = '0;
        n.valid = 1'b0;
        n.grant = '0;
      end else begin
        n.cnt = m.cnt + 4'd1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rdy);
    exp_t e;
    req = r;
    out_ready = rdy;
    m4 = mstep(m4, r, rdy, 4);
    m1 = mstep(m1, r, rdy, 1);
    e.a = m4;
    e.b = m1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("mb4_valid", 32'(valid4), 32'(e.a.valid));
    chk("mb4_sel",   32'(sel4),   32'(e.a.sel));
    chk("mb4_grant", 32'(grant4), 32'(e.a.grant));
    chk("mb4_cnt",   32'(cnt4),   32'(e.a.cnt));
    chk("mb1_valid", 32'(valid1), 32'(e.b.valid));
    chk("mb1_sel",   32'(sel1),   32'(e.b.sel));
    chk("mb1_grant", 32'(grant1), 32'(e.b.grant));
    chk("mb1_cnt",   32'(cnt1),   32'(e.b.cnt));
    if (valid4 && !pv4) ord4.push_back(int'(sel4));
    if (valid1 && !pv1) ord1.push_back(int'(sel1));
    pv4 = valid4;
    pv1 = valid1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m4 = mreset();
    m1 = mreset();
    pv4 = 1'b0;
    pv1 = 1'b0;
    ord4.delete();
    ord1.delete();
    chk("rst_valid", 32'(valid4), 32'd0);
    chk("rst_grant", 32'(grant4), 32'd0);
    chk("rst_sel",   32'(sel4),   32'd0);
    chk("rst_cnt",   32'(cnt4),   32'd0);
    chk("rst_valid1", 32'(valid1), 32'd0);
  endtask

  initial begin
    m4 = mreset();
    m1 = mreset();
    pv4 = 1'b0;
    pv1 = 1'b0;

    // Single request on ch2
    do_reset();
    step(4'b0100, 1'b1);
    chk("r030_sel",   32'(sel4),   32'd2);
    chk("r030_grant", 32'(grant4), 32'b0100);
    chk("r030_valid", 32'(valid4), 32'd1);
    repeat (6) step(4'b0100, 1'b1);
    step(4'b0000, 1'b1);

    // Full request, round-robin order with bursts of 4
    do_reset();
    repeat (24) step(4'b1111, 1'b1);
    chk("r031_ngrants", 32'(ord4.size()), 32'd5);
    for (int i = 0; i < ord4.size() && i < 5; i++)
      chk("r031_order", 32'(ord4[i]), 32'(i % 4));

    // Stall with request dropped: no retraction
    do_reset();
    step(4'b0010, 1'b1);
    chk("r032_sel0", 32'(sel4), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 1'b0);
      chk("r032_hold_v", 32'(valid4), 32'd1);
      chk("r032_hold_s", 32'(sel4), 32'd1);
    end
    step(4'b0000, 1'b1);
    chk("r032_rel", 32'(valid4), 32'd0);

    // Pointer wrap 3 -> 0
    do_reset();
    step(4'b1000, 1'b1);
    chk("r033_sel3", 32'(sel4), 32'd3);
    repeat (4) step(4'b1001, 1'b1);
    chk("r033_bub", 32'(valid4), 32'd0);
    step(4'b1001, 1'b1);
    chk("r033_sel0", 32'(sel4), 32'd0);
    chk("r033_v", 32'(valid4), 32'd1);

    // Async reset mid-burst
    do_reset();
    repeat (3) step(4'b1111, 1'b1);
    chk("r034_cnt2", 32'(cnt4), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("r034_async_v", 32'(valid4), 32'd0);
    chk("r034_async_g", 32'(grant4), 32'd0);
    do_reset();
    step(4'b1010, 1'b1);
    chk("r034_sel1", 32'(sel4), 32'd1);
    chk("r034_g1", 32'(grant4), 32'b0010);

    // MAX_BURST=1 alternation
    do_reset();
    repeat (6) step(4'b0011, 1'b1);
    chk("r035_n", 32'(ord1.size()), 32'd3);
    for (int i = 0; i < ord1.size() && i < 3; i++)
      chk("r035_order", 32'(ord1[i]), 32'(i % 2));

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++)
      step(4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
